// File: rtl/cfu_ram_responder.sv
// cfu_ram_responder: Wishbone-classic responder serving the CFU cfu_ram_* port from a local
// word-addressed memory. Fixed wait states, err on out-of-window addresses, a backdoor preload
// port, and ack/err termination counters.
module cfu_ram_responder #(
   parameter int unsigned ADDR_WIDTH  = 10,
   parameter int unsigned WAIT_STATES = 1,
   parameter logic [29:0] BASE_ADR    = 30'h0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [29:0]           cfu_ram_adr,
   input  logic [31:0]           cfu_ram_dat_mosi,
   input  logic [3:0]            cfu_ram_sel,
   input  logic                  cfu_ram_cyc,
   input  logic                  cfu_ram_stb,
   input  logic                  cfu_ram_we,
   input  logic [2:0]            cfu_ram_cti,
   input  logic [1:0]            cfu_ram_bte,
   output logic [31:0]           cfu_ram_dat_miso,
   output logic                  cfu_ram_ack,
   output logic                  cfu_ram_err,
   input  logic                  bd_we,
   input  logic [ADDR_WIDTH-1:0] bd_adr,
   input  logic [31:0]           bd_dat,
   output logic [15:0]           txn_count,
   output logic [7:0]            err_count
);

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

   // Counter reload value; only meaningful when WAIT_STATES > 0.
   localparam logic [3:0] WaitLoad = 4'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

   // cti/bte are accepted but every access is treated as classic.
   logic unused_burst;
   assign unused_burst = ^{cfu_ram_cti, cfu_ram_bte};

   logic [31:0] mem_q [2**ADDR_WIDTH];

   state_e                  state_q, state_d;
   logic [3:0]              wait_cnt_q, wait_cnt_d;
   logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
   logic                    we_q, we_d;
   logic [3:0]              sel_q, sel_d;
   logic [31:0]             wdat_q, wdat_d;
   logic                    ack_q, ack_d;
   logic                    err_q, err_d;
   logic [31:0]             miso_q, miso_d;
   logic [15:0]             txn_q, txn_d;
   logic [7:0]              errc_q, errc_d;

   // Window decode: the borrow of the subtraction flags adr < BASE_ADR.
   logic                    req_borrow;
   logic [29:0]             req_off;
   logic                    req_in_range;
   logic [ADDR_WIDTH-1:0]   req_idx;

   assign {req_borrow, req_off} = {1'b0, cfu_ram_adr} - {1'b0, BASE_ADR};
   assign req_in_range          = !req_borrow && ((req_off >> ADDR_WIDTH) == 30'd0);
   assign req_idx               = req_off[ADDR_WIDTH-1:0];

   // Memory access performed on the edge that enters RESP with ack.
   logic                    acc_go;
   logic                    acc_we;
   logic [ADDR_WIDTH-1:0]   acc_idx;
   logic [3:0]              acc_sel;
   logic [31:0]             acc_dat;
   logic                    mem_wr_en;
   logic                    bd_hit;
   logic [31:0]             mem_wr_word;

   // Next-state, latched request and registered outputs.
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      idx_d      = idx_q;
      we_d       = we_q;
      sel_d      = sel_q;
      wdat_d     = wdat_q;
      ack_d      = 1'b0;
      err_d      = 1'b0;
      txn_d      = txn_q;
      errc_d     = errc_q;
      acc_go     = 1'b0;
      acc_we     = we_q;
      acc_idx    = idx_q;
      acc_sel    = sel_q;
      acc_dat    = wdat_q;

      unique case (state_q)
         StIdle: begin
            if (cfu_ram_cyc && cfu_ram_stb) begin
               idx_d  = req_idx;
               we_d   = cfu_ram_we;
               sel_d  = cfu_ram_sel;
               wdat_d = cfu_ram_dat_mosi;
               if (!req_in_range) begin
                  state_d = StResp;
                  err_d   = 1'b1;
                  if (errc_q != 8'hFF) begin
                     errc_d = errc_q + 8'd1;
                  end
               end else if (WAIT_STATES == 0) begin
                  state_d = StResp;
                  ack_d   = 1'b1;
                  txn_d   = txn_q + 16'd1;
                  acc_go  = 1'b1;
                  acc_we  = cfu_ram_we;
                  acc_idx = req_idx;
                  acc_sel = cfu_ram_sel;
                  acc_dat = cfu_ram_dat_mosi;
               end else begin
                  state_d    = StWait;
                  wait_cnt_d = WaitLoad;
               end
            end
         end
         StWait: begin
            if (!cfu_ram_cyc) begin
               // Initiator abandoned the cycle: no termination, no memory change.
               state_d = StIdle;
            end else if (wait_cnt_q == 4'd0) begin
               state_d = StResp;
               ack_d   = 1'b1;
               txn_d   = txn_q + 16'd1;
               acc_go  = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q - 4'd1;
            end
         end
         StResp: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Read data and merged write word; bus lanes override a colliding backdoor write.
   always_comb begin
      miso_d      = 32'd0;
      mem_wr_en   = acc_go && acc_we && !reset;
      bd_hit      = bd_we && (bd_adr == acc_idx);
      mem_wr_word = mem_q[acc_idx];
      if (acc_go && !acc_we) begin
         miso_d = mem_q[acc_idx];
      end
      for (int i = 0; i < 4; i++) begin
         if (acc_sel[i]) begin
            mem_wr_word[8*i +: 8] = acc_dat[8*i +: 8];
         end else if (bd_hit) begin
            mem_wr_word[8*i +: 8] = bd_dat[8*i +: 8];
         end
      end
   end

   // Memory array; contents survive reset.
   always_ff @(posedge clk) begin
      if (bd_we && !(mem_wr_en && (bd_adr == acc_idx))) begin
         mem_q[bd_adr] <= bd_dat;
      end
      if (mem_wr_en) begin
         mem_q[acc_idx] <= mem_wr_word;
      end
   end

   // Control state, latched request, outputs and counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         wait_cnt_q <= 4'd0;
         idx_q      <= '0;
         we_q       <= 1'b0;
         sel_q      <= 4'd0;
         wdat_q     <= 32'd0;
         ack_q      <= 1'b0;
         err_q      <= 1'b0;
         miso_q     <= 32'd0;
         txn_q      <= 16'd0;
         errc_q     <= 8'd0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         idx_q      <= idx_d;
         we_q       <= we_d;
         sel_q      <= sel_d;
         wdat_q     <= wdat_d;
         ack_q      <= ack_d;
         err_q      <= err_d;
         miso_q     <= miso_d;
         txn_q      <= txn_d;
         errc_q     <= errc_d;
      end
   end

   assign cfu_ram_dat_miso = miso_q;
   assign cfu_ram_ack      = ack_q;
   assign cfu_ram_err      = err_q;
   assign txn_count        = txn_q;
   assign err_count        = errc_q;

endmodule

// File: tb/tb_cfu_ram_responder.sv
// Bench for cfu_ram_responder: two instances (1 and 3 wait states, different bases) sharing
// address/data/backdoor inputs with separate cyc/stb. Stimulus pushes expected responses into
// per-instance queues; negedge monitors pop and compare whenever ack or err is seen.
module tb_cfu_ram_responder;

   localparam int unsigned W1 = 1;
   localparam int unsigned W3 = 3;

   typedef struct {
      bit          is_err;
      logic [31:0] dat;
      int unsigned cyc;
      logic [15:0] txn;
      logic [7:0]  errc;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [29:0] adr = '0;
   logic [31:0] mosi = '0;
   logic [3:0]  sel = '0;
   logic        we = 1'b0;
   logic [2:0]  cti = 3'b010;
   logic [1:0]  bte = 2'b01;
   logic        cyc1 = 1'b0, stb1 = 1'b0, cyc3 = 1'b0, stb3 = 1'b0;
   logic        bd_we = 1'b0;
   logic [9:0]  bd_adr = '0;
   logic [31:0] bd_dat = '0;

   logic [31:0] miso1, miso3;
   logic        ack1, err1, ack3, err3;
   logic [15:0] txn1, txn3;
   logic [7:0]  errc1, errc3;

   int unsigned cyc_n = 0;
   int unsigned vectors = 0;
   int unsigned miscompares = 0;
   exp_t        q1[$], q3[$];
   exp_t        m1, m3;

   cfu_ram_responder #(.ADDR_WIDTH(10), .WAIT_STATES(W1), .BASE_ADR(30'h0)) u_dut1 (
      .clk(clk), .reset(reset), .cfu_ram_adr(adr), .cfu_ram_dat_mosi(mosi),
      .cfu_ram_sel(sel), .cfu_ram_cyc(cyc1), .cfu_ram_stb(stb1), .cfu_ram_we(we),
      .cfu_ram_cti(cti), .cfu_ram_bte(bte), .cfu_ram_dat_miso(miso1), .cfu_ram_ack(ack1),
      .cfu_ram_err(err1), .bd_we(bd_we), .bd_adr(bd_adr), .bd_dat(bd_dat),
      .txn_count(txn1), .err_count(errc1)
   );

   cfu_ram_responder #(.ADDR_WIDTH(10), .WAIT_STATES(W3), .BASE_ADR(30'h100)) u_dut3 (
      .clk(clk), .reset(reset), .cfu_ram_adr(adr), .cfu_ram_dat_mosi(mosi),
      .cfu_ram_sel(sel), .cfu_ram_cyc(cyc3), .cfu_ram_stb(stb3), .cfu_ram_we(we),
      .cfu_ram_cti(cti), .cfu_ram_bte(bte), .cfu_ram_dat_miso(miso3), .cfu_ram_ack(ack3),
      .cfu_ram_err(err3), .bd_we(bd_we), .bd_adr(bd_adr), .bd_dat(bd_dat),
      .txn_count(txn3), .err_count(errc3)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc_n <= cyc_n + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc_n);
      end
   endtask

   task automatic check_resp(input string tag, input logic a, input logic e,
                             input logic [31:0] d, input logic [15:0] t, input logic [7:0] ec,
                             input exp_t x);
      chk({tag, "_kind"}, {30'd0, a, e}, {30'd0, !x.is_err, x.is_err});
      chk({tag, "_data"}, d, x.dat);
      chk({tag, "_cycle"}, cyc_n, x.cyc);
      chk({tag, "_txn_count"}, {16'd0, t}, {16'd0, x.txn});
      chk({tag, "_err_count"}, {24'd0, ec}, {24'd0, x.errc});
   endtask

   // Monitor for the 1-wait-state instance.
   always @(negedge clk) begin
      if (ack1 || err1) begin
         if (q1.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL dut1_unexpected: ack=%0b err=%0b at cycle %0d, want no response",
                     ack1, err1, cyc_n);
         end else begin
            m1 = q1.pop_front();
            check_resp("dut1", ack1, err1, miso1, txn1, errc1, m1);
         end
      end
   end

   // Monitor for the 3-wait-state instance.
   always @(negedge clk) begin
      if (ack3 || err3) begin
         if (q3.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL dut3_unexpected: ack=%0b err=%0b at cycle %0d, want no response",
                     ack3, err3, cyc_n);
         end else begin
            m3 = q3.pop_front();
            check_resp("dut3", ack3, err3, miso3, txn3, errc3, m3);
         end
      end
   end

   task automatic bd_write(input logic [9:0] i, input logic [31:0] d);
      bd_we  = 1'b1;
      bd_adr = i;
      bd_dat = d;
      @(posedge clk);
      #1;
      bd_we = 1'b0;
   endtask

   // One bus request; optional backdoor write timed to the edge that enters RESP.
   task automatic req(input int dut, input logic w, input logic [29:0] a, input logic [3:0] s,
                      input logic [31:0] d, input bit e_err, input logic [31:0] e_dat,
                      input logic [15:0] e_txn, input logic [7:0] e_errc,
                      input bit bd_on, input logic [9:0] bd_i, input logic [31:0] bd_d);
      exp_t        x;
      int unsigned lat;
      lat  = e_err ? 0 : ((dut == 1) ? W1 : W3);
      adr  = a;
      we   = w;
      sel  = s;
      mosi = d;
      if (dut == 1) begin
         cyc1 = 1'b1;
         stb1 = 1'b1;
      end else begin
         cyc3 = 1'b1;
         stb3 = 1'b1;
      end
      x.is_err = e_err;
      x.dat    = e_dat;
      x.cyc    = cyc_n + 1 + lat;
      x.txn    = e_txn;
      x.errc   = e_errc;
      if (dut == 1) q1.push_back(x);
      else q3.push_back(x);
      if (bd_on) begin
         repeat (lat) @(posedge clk);
         #1;
         bd_we  = 1'b1;
         bd_adr = bd_i;
         bd_dat = bd_d;
         @(posedge clk);
         #1;
         bd_we = 1'b0;
         @(posedge clk);
         #1;
      end else begin
         repeat (lat + 2) @(posedge clk);
         #1;
      end
      cyc1 = 1'b0;
      stb1 = 1'b0;
      cyc3 = 1'b0;
      stb3 = 1'b0;
      we   = 1'b0;
   endtask

   initial begin
      exp_t x;
      int unsigned c;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_ack", {31'd0, ack1}, 32'd0);
      chk("rst_err", {31'd0, err1}, 32'd0);
      chk("rst_dat_miso", miso1, 32'd0);
      chk("rst_txn_count", {16'd0, txn1}, 32'd0);
      chk("rst_err_count", {24'd0, errc1}, 32'd0);
      chk("rst_dut3_txn_count", {16'd0, txn3}, 32'd0);
      chk("rst_dut3_err_count", {24'd0, errc3}, 32'd0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      bd_write(10'd5, 32'hDEAD_BEEF);
      bd_write(10'd7, 32'hAABB_CCDD);
      bd_write(10'd2, 32'h0000_0000);
      bd_write(10'd9, 32'hCAFE_F00D);

      // Plain read, byte-lane write then readback, out-of-window read.
      req(1, 1'b0, 30'd5, 4'hF, 32'd0, 1'b0, 32'hDEAD_BEEF, 16'd1, 8'd0, 1'b0, 10'd0, 32'd0);
      req(1, 1'b1, 30'd7, 4'b0101, 32'h1122_3344, 1'b0, 32'd0, 16'd2, 8'd0, 1'b0, 10'd0, 32'd0);
      req(1, 1'b0, 30'd7, 4'hF, 32'd0, 1'b0, 32'hAA22_CC44, 16'd3, 8'd0, 1'b0, 10'd0, 32'd0);
      req(1, 1'b0, 30'd1024, 4'hF, 32'd0, 1'b1, 32'd0, 16'd3, 8'd1, 1'b0, 10'd0, 32'd0);

      // cyc/stb held across two reads: second is taken at the IDLE edge after RESP.
      c    = cyc_n;
      adr  = 30'd9;
      we   = 1'b0;
      sel  = 4'hF;
      cyc1 = 1'b1;
      stb1 = 1'b1;
      x.is_err = 1'b0;
      x.dat    = 32'hCAFE_F00D;
      x.cyc    = c + 1 + W1;
      x.txn    = 16'd4;
      x.errc   = 8'd1;
      q1.push_back(x);
      x.cyc = c + 1 + W1 + 2 + W1;
      x.txn = 16'd5;
      q1.push_back(x);
      repeat (2 * W1 + 4) @(posedge clk);
      #1;
      cyc1 = 1'b0;
      stb1 = 1'b0;

      // sel=0000 write acks and leaves the word alone.
      req(1, 1'b1, 30'd5, 4'h0, 32'hFFFF_FFFF, 1'b0, 32'd0, 16'd6, 8'd1, 1'b0, 10'd0, 32'd0);
      req(1, 1'b0, 30'd5, 4'hF, 32'd0, 1'b0, 32'hDEAD_BEEF, 16'd7, 8'd1, 1'b0, 10'd0, 32'd0);

      // Bus write colliding with a backdoor write: bus lanes win, other lanes take bd_dat.
      req(1, 1'b1, 30'd9, 4'b0011, 32'h0000_1234, 1'b0, 32'd0, 16'd8, 8'd1,
          1'b1, 10'd9, 32'h5566_7788);
      req(1, 1'b0, 30'd9, 4'hF, 32'd0, 1'b0, 32'h5566_1234, 16'd9, 8'd1, 1'b0, 10'd0, 32'd0);

      // Bus read colliding with a backdoor write returns the old word.
      req(1, 1'b0, 30'd5, 4'hF, 32'd0, 1'b0, 32'hDEAD_BEEF, 16'd10, 8'd1,
          1'b1, 10'd5, 32'h0BAD_F00D);
      req(1, 1'b0, 30'd5, 4'hF, 32'd0, 1'b0, 32'h0BAD_F00D, 16'd11, 8'd1, 1'b0, 10'd0, 32'd0);

      // 3-wait-state instance: write aborted by dropping cyc in WAIT.
      adr  = 30'h102;
      we   = 1'b1;
      sel  = 4'hF;
      mosi = 32'h0000_0055;
      cyc3 = 1'b1;
      stb3 = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      cyc3 = 1'b0;
      stb3 = 1'b0;
      we   = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      req(3, 1'b0, 30'h102, 4'hF, 32'd0, 1'b0, 32'd0, 16'd1, 8'd0, 1'b0, 10'd0, 32'd0);
      req(3, 1'b0, 30'h0FF, 4'hF, 32'd0, 1'b1, 32'd0, 16'd1, 8'd1, 1'b0, 10'd0, 32'd0);
      req(3, 1'b0, 30'h500, 4'hF, 32'd0, 1'b1, 32'd0, 16'd1, 8'd2, 1'b0, 10'd0, 32'd0);
      req(3, 1'b0, 30'h105, 4'hF, 32'd0, 1'b0, 32'h0BAD_F00D, 16'd2, 8'd2, 1'b0, 10'd0, 32'd0);

      // Reset asserted while the 1-wait-state instance is in WAIT.
      adr  = 30'd7;
      we   = 1'b0;
      sel  = 4'hF;
      cyc1 = 1'b1;
      stb1 = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      chk("midrst_ack", {31'd0, ack1}, 32'd0);
      chk("midrst_err", {31'd0, err1}, 32'd0);
      chk("midrst_dat_miso", miso1, 32'd0);
      chk("midrst_txn_count", {16'd0, txn1}, 32'd0);
      chk("midrst_err_count", {24'd0, errc1}, 32'd0);
      chk("midrst_dut3_err_count", {24'd0, errc3}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      cyc1  = 1'b0;
      stb1  = 1'b0;
      @(posedge clk);
      #1;
      req(1, 1'b0, 30'd7, 4'hF, 32'd0, 1'b0, 32'hAA22_CC44, 16'd1, 8'd0, 1'b0, 10'd0, 32'd0);

      repeat (4) @(posedge clk);
      #1;
      chk("dut1_queue_drained", q1.size(), 32'd0);
      chk("dut3_queue_drained", q3.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
